// File: rtl/ysyx_22040895_idu_stage.sv
// ysyx_22040895_idu_stage: registered handshaked decode stage with 1/2-entry output buffer; YSYX_22040895_IDU_ILLEGAL_EN adds illegal_o checking
module ysyx_22040895_idu_stage #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        func3_o,
  output logic [6:0]        func7_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        rd_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [5:0]        itype_o,
  output logic              rs1_en_o,
  output logic              rs2_en_o,
  output logic              rd_we_o,
  output logic              illegal_o
);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   imm;
    logic [5:0]        itype;
    logic              rs1_en;
    logic              rs2_en;
    logic              rd_we;
    logic              illegal;
  } bundle_t;
  localparam int CW = $clog2(DEPTH + 1);
  bundle_t           mem_q [DEPTH];
  bundle_t           mem_d [DEPTH];
  bundle_t           dec;
  logic [CW-1:0]     cnt;
  logic [6:0]        op;
  logic signed [31:0] imm32;
  logic              r, i, s, b, u, j, ill, push, pop;
  assign op = inst_i[6:0];
  always_comb begin
    r = op == 7'b0110011 || op == 7'b0111011;
    i = op == 7'b0010011 || op == 7'b0011011 || op == 7'b0000011 || op == 7'b1100111 || op == 7'b1110011;
    s = op == 7'b0100011;
    b = op == 7'b1100011;
    u = op == 7'b0110111 || op == 7'b0010111;
    j = op == 7'b1101111;
    imm32 = i ? {{20{inst_i[31]}}, inst_i[31:20]} :
            s ? {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]} :
            b ? {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0} :
            u ? {inst_i[31:12], 12'b0} :
            j ? {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0} : '0;
`ifdef YSYX_22040895_IDU_ILLEGAL_EN
    ill = !(r | i | s | b | u | j) || inst_i[1:0] != 2'b11 || inst_i == 32'h0;
`else
    ill = 1'b0;
`endif
    dec = '{pc: pc_i, opcode: op, func3: inst_i[14:12], func7: inst_i[31:25],
            rs1: inst_i[19:15], rs2: inst_i[24:20], rd: inst_i[11:7],
            imm: XLEN'(imm32), itype: {j, u, b, s, i, r},
            rs1_en: r | i | s | b, rs2_en: r | s | b, rd_we: (r | i | u | j) & ~ill,
            illegal: ill};
  end
  assign out_valid_o = cnt != '0;
  assign in_ready_o  = cnt != CW'(DEPTH) || (DEPTH == 1 && out_ready_i);
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i;
  // shift-down FIFO: head always in slot 0, new beat lands behind the survivors
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      mem_d[k] = pop ? mem_q[(k + 1) % DEPTH] : mem_q[k];
      if (push && k == int'(cnt) - int'(pop)) mem_d[k] = dec;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      cnt <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      cnt   <= cnt + CW'(push) - CW'(pop);
      mem_q <= mem_d;
    end
  end
  assign pc_o      = mem_q[0].pc;
  assign opcode_o  = mem_q[0].opcode;
  assign func3_o   = mem_q[0].func3;
  assign func7_o   = mem_q[0].func7;
  assign rs1_o     = mem_q[0].rs1;
  assign rs2_o     = mem_q[0].rs2;
  assign rd_o      = mem_q[0].rd;
  assign imm_o     = mem_q[0].imm;
  assign itype_o   = mem_q[0].itype;
  assign rs1_en_o  = mem_q[0].rs1_en;
  assign rs2_en_o  = mem_q[0].rs2_en;
  assign rd_we_o   = mem_q[0].rd_we;
  assign illegal_o = mem_q[0].illegal;
endmodule

// File: tb/tb_ysyx_22040895_idu_stage.sv
// tb_ysyx_22040895_idu_stage: directed checks of decode, skid buffering, flush and reset
module tb_ysyx_22040895_idu_stage;
  logic        clk = 0, rst = 1, flush_i = 0, in_valid_i = 0, out_ready_i = 0;
  logic        in_ready_o, out_valid_o, rs1_en_o, rs2_en_o, rd_we_o, illegal_o;
  logic [31:0] inst_i = 0;
  logic [63:0] pc_i = 0, pc_o, imm_o;
  logic [6:0]  opcode_o, func7_o;
  logic [2:0]  func3_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [5:0]  itype_o;
  int checks = 0, failures = 0;
`ifdef YSYX_22040895_IDU_ILLEGAL_EN
  localparam logic ILL_ON = 1'b1;
`else
  localparam logic ILL_ON = 1'b0;
`endif
  ysyx_22040895_idu_stage dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .pc_i(pc_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .opcode_o(opcode_o), .func3_o(func3_o), .func7_o(func7_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o), .itype_o(itype_o),
    .rs1_en_o(rs1_en_o), .rs2_en_o(rs2_en_o), .rd_we_o(rd_we_o), .illegal_o(illegal_o));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] addi(input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, 5'd1, 7'b0010011};
  endfunction
  task automatic test_reset;
    rst = 1; step; step;
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
    checks++; if ({pc_o, imm_o, itype_o, rd_we_o, illegal_o} !== '0) begin failures++; $display("FAIL reset_bundle pc=%h imm=%h itype=%b", pc_o, imm_o, itype_o); end
    rst = 0;
  endtask
  task automatic test_addi;
    out_ready_i = 1; in_valid_i = 1; inst_i = 32'hFFF00093; pc_i = 64'h8000_0000; step;
    in_valid_i = 0;
    checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b exp=1", out_valid_o); end
    checks++; if (imm_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL addi_imm got=%h exp=%h", imm_o, 64'hFFFF_FFFF_FFFF_FFFF); end
    checks++; if ({rd_o, itype_o, rd_we_o, rs1_en_o, rs2_en_o} !== {5'd1, 6'b000010, 3'b110}) begin failures++; $display("FAIL addi_fields rd=%0d itype=%b en=%b%b%b exp rd=1 itype=000010 en=110", rd_o, itype_o, rd_we_o, rs1_en_o, rs2_en_o); end
    checks++; if (pc_o !== 64'h8000_0000) begin failures++; $display("FAIL addi_pc got=%h exp=80000000", pc_o); end
    step;
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL addi_drain got=%b exp=0", out_valid_o); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] ins [5] = '{32'h0020A423, 32'hFE000EE3, 32'hFF9FF06F, 32'h123452B7, 32'h002081B3};
    logic [63:0] imm [5] = '{64'd8, -64'sd4, -64'sd8, 64'h1234_5000, 64'd0};
    logic [5:0]  ity [5] = '{6'b000100, 6'b001000, 6'b100000, 6'b010000, 6'b000001};
    logic [2:0]  en  [5] = '{3'b011, 3'b011, 3'b100, 3'b100, 3'b111};
    out_ready_i = 1; in_valid_i = 1;
    for (int k = 0; k < 5; k++) begin
      inst_i = ins[k]; pc_i = 64'h200 + 64'(4 * k); step;
      checks++; if (out_valid_o !== 1'b1 || pc_o !== 64'h200 + 64'(4 * k)) begin failures++; $display("FAIL b2b_pc[%0d] valid=%b got=%h", k, out_valid_o, pc_o); end
      checks++; if (imm_o !== imm[k] || itype_o !== ity[k]) begin failures++; $display("FAIL b2b_dec[%0d] imm=%h itype=%b exp imm=%h itype=%b", k, imm_o, itype_o, imm[k], ity[k]); end
      checks++; if ({rd_we_o, rs1_en_o, rs2_en_o} !== en[k]) begin failures++; $display("FAIL b2b_en[%0d] got=%b%b%b exp=%b", k, rd_we_o, rs1_en_o, rs2_en_o, en[k]); end
    end
    checks++; if ({rs1_o, rs2_o, rd_o, func3_o, func7_o, opcode_o} !== {5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 7'b0110011}) begin failures++; $display("FAIL b2b_rfields rs1=%0d rs2=%0d rd=%0d op=%b", rs1_o, rs2_o, rd_o, opcode_o); end
    in_valid_i = 0; step;
  endtask
  task automatic test_backpressure;
    out_ready_i = 0; in_valid_i = 1;
    inst_i = addi(12'd1); pc_i = 64'h100; step;
    checks++; if (out_valid_o !== 1'b1 || pc_o !== 64'h100 || in_ready_o !== 1'b1) begin failures++; $display("FAIL bp_first valid=%b pc=%h ready=%b", out_valid_o, pc_o, in_ready_o); end
    inst_i = addi(12'd2); pc_i = 64'h104; step;
    checks++; if (in_ready_o !== 1'b0 || pc_o !== 64'h100) begin failures++; $display("FAIL bp_full ready=%b pc=%h exp ready=0 pc=100", in_ready_o, pc_o); end
    inst_i = addi(12'd3); pc_i = 64'h108; step;
    checks++; if (in_ready_o !== 1'b0 || pc_o !== 64'h100 || imm_o !== 64'd1 || out_valid_o !== 1'b1) begin failures++; $display("FAIL bp_hold ready=%b pc=%h imm=%h", in_ready_o, pc_o, imm_o); end
    out_ready_i = 1; step;
    checks++; if (out_valid_o !== 1'b1 || pc_o !== 64'h104 || imm_o !== 64'd2) begin failures++; $display("FAIL bp_rel1 pc=%h imm=%h exp pc=104 imm=2", pc_o, imm_o); end
    step;
    checks++; if (out_valid_o !== 1'b1 || pc_o !== 64'h108 || imm_o !== 64'd3) begin failures++; $display("FAIL bp_rel2 pc=%h imm=%h exp pc=108 imm=3", pc_o, imm_o); end
    for (int k = 0; k < 3; k++) begin
      inst_i = addi(12'(4 + k)); pc_i = 64'h10C + 64'(4 * k); step;
      checks++; if (pc_o !== 64'h10C + 64'(4 * k) || in_ready_o !== 1'b1 || imm_o !== 64'(4 + k)) begin failures++; $display("FAIL bp_stream[%0d] pc=%h ready=%b imm=%h", k, pc_o, in_ready_o, imm_o); end
    end
    in_valid_i = 0; step;
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid_o); end
  endtask
  task automatic test_flush;
    out_ready_i = 0; in_valid_i = 1;
    inst_i = addi(12'd7); pc_i = 64'h300; step;
    pc_i = 64'h304; step;
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL flush_prefull ready=%b exp=0", in_ready_o); end
    out_ready_i = 1; pc_i = 64'h308; flush_i = 1; step;
    flush_i = 0; in_valid_i = 0;
    checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin failures++; $display("FAIL flush_empty valid=%b ready=%b", out_valid_o, in_ready_o); end
    for (int k = 0; k < 3; k++) begin
      step;
      checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_ghost[%0d] valid=%b pc=%h", k, out_valid_o, pc_o); end
    end
  endtask
  task automatic test_midstream_reset;
    out_ready_i = 1; in_valid_i = 1; inst_i = addi(12'd9); pc_i = 64'h400; step;
    rst = 1; pc_i = 64'h404; step;
    checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid valid=%b ready=%b", out_valid_o, in_ready_o); end
    checks++; if ({pc_o, imm_o, itype_o, rd_o} !== '0) begin failures++; $display("FAIL rst_mid_zero pc=%h imm=%h itype=%b", pc_o, imm_o, itype_o); end
    rst = 0; inst_i = 32'h123452B7; pc_i = 64'h408; step;
    in_valid_i = 0;
    checks++; if (out_valid_o !== 1'b1 || imm_o !== 64'h1234_5000 || rd_o !== 5'd5 || itype_o !== 6'b010000) begin failures++; $display("FAIL rst_after valid=%b imm=%h rd=%0d itype=%b", out_valid_o, imm_o, rd_o, itype_o); end
    step;
  endtask
  task automatic test_illegal;
    logic [31:0] ins [3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFF00093};
    logic        ill [3] = '{ILL_ON, ILL_ON, 1'b0};
    logic        we  [3] = '{1'b0, 1'b0, 1'b1};
    out_ready_i = 1; in_valid_i = 1;
    for (int k = 0; k < 3; k++) begin
      inst_i = ins[k]; pc_i = 64'h500 + 64'(4 * k); step;
      checks++; if (illegal_o !== ill[k] || rd_we_o !== we[k]) begin failures++; $display("FAIL illegal[%0d] ill=%b we=%b exp ill=%b we=%b", k, illegal_o, rd_we_o, ill[k], we[k]); end
      checks++; if (k < 2 && (itype_o !== 6'b0 || imm_o !== 64'd0 || rs1_en_o !== 1'b0)) begin failures++; $display("FAIL unknown[%0d] itype=%b imm=%h", k, itype_o, imm_o); end
    end
    in_valid_i = 0; step;
  endtask
  initial begin
    test_reset;
    test_addi;
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_midstream_reset;
    test_illegal;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
